// File: rtl/memory_bus_router_pkg.sv
// Shared definitions for the memory bus router: FSM encoding, counter widths,
// the error read pattern and the bank-field extraction helper.
package memory_bus_router_pkg;

    // Width of one per-bank wait-state field and of the timeout counter
    localparam int unsigned WAIT_FIELD_W = 4;
    localparam int unsigned TO_W         = 8;

    // FSM state encoding
    localparam int unsigned ST_W      = 2;
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;

    // Read data returned on timeout or unmapped bank (truncated to DATA_WIDTH)
    localparam logic [63:0] ERR_DATA = '1;

    // Status of the wait/timeout timer
    typedef struct packed {
        logic wait_done;
        logic expired;
    } timer_status_t;

    // Extract addr[msb -: bits] as an integer bank index
    function automatic int unsigned bank_field(input logic [63:0] addr,
                                               input int unsigned msb,
                                               input int unsigned bits);
        logic [63:0] mask;
        mask = (64'd1 << bits) - 64'd1;
        return 32'((addr >> (msb - bits + 1)) & mask);
    endfunction

endpackage

// File: rtl/memory_bus_router_if.sv
// CPU-side and bank-side signals of the memory bus router.
//   master : CPU / bank environment (drives requests, bank read data and ready)
//   slave  : the router (drives completion, read data and bank strobes)
interface memory_bus_router_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_BANKS  = 4
);
    logic                            bus_enable;
    logic                            write_enable;
    logic [ADDR_WIDTH-1:0]           address;
    logic [DATA_WIDTH-1:0]           data_in;
    logic [DATA_WIDTH-1:0]           data_out;
    logic                            ready;
    logic                            error;
    logic [NUM_BANKS-1:0]            bank_enable;
    logic [NUM_BANKS-1:0]            bank_write_enable;
    logic [ADDR_WIDTH-1:0]           bank_address;
    logic [DATA_WIDTH-1:0]           bank_wdata;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata;
    logic [NUM_BANKS-1:0]            bank_ready;

    modport master (
        output bus_enable, write_enable, address, data_in, bank_rdata, bank_ready,
        input  data_out, ready, error, bank_enable, bank_write_enable,
               bank_address, bank_wdata
    );

    modport slave (
        input  bus_enable, write_enable, address, data_in, bank_rdata, bank_ready,
        output data_out, ready, error, bank_enable, bank_write_enable,
               bank_address, bank_wdata
    );

endinterface

// File: rtl/memory_bus_router_wait_timer.sv
// bus_wait_timer: loadable wait-state down-counter plus timeout up-counter.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   i_load       load i_wait_val into the wait counter and clear the timeout counter
//   i_wait_val   wait-state count for the selected bank
//   i_tick       advance: count wait states down first, then timeout up
//   o_status_c   wait_done (wait counter at 0), expired (timeout counter at TIMEOUT)
module bus_wait_timer
    import memory_bus_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [WAIT_FIELD_W-1:0] i_wait_val,
    input  logic                    i_tick,
    output timer_status_t           o_status_c
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [WAIT_FIELD_W-1:0] r_wait_cnt;
    logic [TO_W-1:0]         r_to_cnt;

    // Both counters stop at their terminal value, so neither can wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (i_load) begin
            r_wait_cnt <= i_wait_val;
            r_to_cnt   <= '0;
        end else if (i_tick) begin
            if (r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - WAIT_FIELD_W'(1);
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign o_status_c.wait_done = (r_wait_cnt == '0);
    assign o_status_c.expired   = (r_to_cnt == TO_MAX);

endmodule

// File: rtl/memory_bus_router.sv
// memory_bus_router: routes latched CPU reads/writes to one of 2**BANK_BITS banks
// selected by address[BANK_MSB -: BANK_BITS], with per-bank wait states, a
// bank_ready handshake, a timeout and unmapped-bank detection.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    memory_bus_router_if.slave: CPU request/response and bank strobes
module memory_bus_router
    import memory_bus_router_pkg::*;
#(
    parameter int unsigned                            ADDR_WIDTH   = 16,
    parameter int unsigned                            DATA_WIDTH   = 16,
    parameter int unsigned                            BANK_BITS    = 2,
    parameter int unsigned                            BANK_MSB     = 14,
    parameter logic [(1<<BANK_BITS)-1:0]              BANK_PRESENT = '1,
    parameter logic [WAIT_FIELD_W*(1<<BANK_BITS)-1:0] WAIT_STATES  = '0,
    parameter int unsigned                            TIMEOUT      = 255
)(
    input  logic              clk,
    input  logic              reset,
    memory_bus_router_if.slave bus
);

    localparam int unsigned NUM_BANKS = 1 << BANK_BITS;

    logic [ST_W-1:0]       r_state;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_ready;
    logic                  r_error;
    logic [NUM_BANKS-1:0]  r_bank_en;
    logic [NUM_BANKS-1:0]  r_bank_we;
    logic [ADDR_WIDTH-1:0] r_bank_addr;
    logic [DATA_WIDTH-1:0] r_bank_wdata;
    logic                  r_we;
    logic [BANK_BITS-1:0]  r_bank;

    logic [ST_W-1:0]       w_state_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;
    logic                  w_ready_nxt;
    logic                  w_error_nxt;
    logic [NUM_BANKS-1:0]  w_bank_en_nxt;
    logic [NUM_BANKS-1:0]  w_bank_we_nxt;
    logic [ADDR_WIDTH-1:0] w_bank_addr_nxt;
    logic [DATA_WIDTH-1:0] w_bank_wdata_nxt;
    logic                  w_we_nxt;
    logic [BANK_BITS-1:0]  w_bank_nxt;

    logic [BANK_BITS-1:0]    w_req_bank;
    logic [NUM_BANKS-1:0]    w_req_onehot;
    logic                    w_req_present;
    logic [WAIT_FIELD_W-1:0] w_req_wait;
    logic                    w_sel_ready;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic                    w_load;
    logic                    w_tick;
    timer_status_t           w_timer;

    assign w_req_bank = BANK_BITS'(bank_field(64'(bus.address), BANK_MSB, BANK_BITS));

    // Decode the incoming request's bank: one-hot, mapped flag and wait field
    always_comb begin
        w_req_onehot  = '0;
        w_req_present = 1'b0;
        w_req_wait    = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (w_req_bank == BANK_BITS'(i)) begin
                w_req_onehot[i] = 1'b1;
                w_req_present   = BANK_PRESENT[i];
                w_req_wait      = WAIT_STATES[i*WAIT_FIELD_W +: WAIT_FIELD_W];
            end
        end
    end

    // Only the latched bank's ready and read data are looked at
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (r_bank == BANK_BITS'(i)) begin
                w_sel_ready = bus.bank_ready[i];
                w_sel_rdata = bus.bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_tick = (r_state == ST_ACCESS);

    bus_wait_timer #(
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_wait_val (w_req_wait),
        .i_tick     (w_tick),
        .o_status_c (w_timer)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_data_out_nxt   = r_data_out;
        w_ready_nxt      = 1'b0;
        w_error_nxt      = 1'b0;
        w_bank_en_nxt    = r_bank_en;
        w_bank_we_nxt    = r_bank_we;
        w_bank_addr_nxt  = r_bank_addr;
        w_bank_wdata_nxt = r_bank_wdata;
        w_we_nxt         = r_we;
        w_bank_nxt       = r_bank;
        w_load           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.bus_enable) begin
                    w_bank_addr_nxt  = bus.address;
                    w_bank_wdata_nxt = bus.data_in;
                    w_we_nxt         = bus.write_enable;
                    w_bank_nxt       = w_req_bank;
                    if (!w_req_present) begin
                        // Unmapped: complete immediately, no strobes
                        w_state_nxt    = ST_DONE;
                        w_ready_nxt    = 1'b1;
                        w_error_nxt    = 1'b1;
                        w_data_out_nxt = DATA_WIDTH'(ERR_DATA);
                        w_bank_en_nxt  = '0;
                        w_bank_we_nxt  = '0;
                    end else begin
                        w_load        = 1'b1;
                        w_state_nxt   = ST_ACCESS;
                        w_bank_en_nxt = w_req_onehot;
                        w_bank_we_nxt = w_req_onehot & {NUM_BANKS{bus.write_enable}};
                    end
                end
            end

            ST_ACCESS: begin
                // bank_ready is ignored until the wait states have elapsed
                if (w_timer.wait_done) begin
                    if (w_sel_ready) begin
                        w_state_nxt   = ST_DONE;
                        w_ready_nxt   = 1'b1;
                        w_bank_en_nxt = '0;
                        w_bank_we_nxt = '0;
                        if (!r_we) begin
                            w_data_out_nxt = w_sel_rdata;
                        end
                    end else if (w_timer.expired) begin
                        w_state_nxt    = ST_DONE;
                        w_ready_nxt    = 1'b1;
                        w_error_nxt    = 1'b1;
                        w_data_out_nxt = DATA_WIDTH'(ERR_DATA);
                        w_bank_en_nxt  = '0;
                        w_bank_we_nxt  = '0;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_bank_en_nxt = '0;
                w_bank_we_nxt = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_data_out   <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
            r_bank_en    <= '0;
            r_bank_we    <= '0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_we         <= 1'b0;
            r_bank       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_out   <= w_data_out_nxt;
            r_ready      <= w_ready_nxt;
            r_error      <= w_error_nxt;
            r_bank_en    <= w_bank_en_nxt;
            r_bank_we    <= w_bank_we_nxt;
            r_bank_addr  <= w_bank_addr_nxt;
            r_bank_wdata <= w_bank_wdata_nxt;
            r_we         <= w_we_nxt;
            r_bank       <= w_bank_nxt;
        end
    end

    assign bus.data_out          = r_data_out;
    assign bus.ready             = r_ready;
    assign bus.error             = r_error;
    assign bus.bank_enable       = r_bank_en;
    assign bus.bank_write_enable = r_bank_we;
    assign bus.bank_address      = r_bank_addr;
    assign bus.bank_wdata        = r_bank_wdata;

endmodule

// File: tb/tb_memory_bus_router.sv
// Testbench for memory_bus_router. Two instances: dut_a with default parameters,
// dut_b with bank 1 wait states, a short timeout and bank 3 unmapped.
module tb_memory_bus_router;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          edges;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        cpu_en;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [63:0] rdata_a;
    logic [63:0] rdata_b;
    logic [3:0]  rdy_a;
    logic [3:0]  rdy_b;

    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    memory_bus_router_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_BANKS(4)) bus_a ();
    memory_bus_router_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_BANKS(4)) bus_b ();

    memory_bus_router dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    memory_bus_router #(
        .WAIT_STATES  (16'h0030),
        .TIMEOUT      (4),
        .BANK_PRESENT (4'b0111)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.bus_enable   = cpu_en & ~sel;
    assign bus_b.bus_enable   = cpu_en & sel;
    assign bus_a.write_enable = cpu_we;
    assign bus_b.write_enable = cpu_we;
    assign bus_a.address      = cpu_addr;
    assign bus_b.address      = cpu_addr;
    assign bus_a.data_in      = cpu_wdata;
    assign bus_b.data_in      = cpu_wdata;
    assign bus_a.bank_rdata   = rdata_a;
    assign bus_b.bank_rdata   = rdata_b;
    assign bus_a.bank_ready   = rdy_a;
    assign bus_b.bank_ready   = rdy_b;

    logic        obs_ready;
    logic        obs_err;
    logic [15:0] obs_dout;
    logic [15:0] obs_addr;
    logic [15:0] obs_wdata;
    logic [3:0]  obs_en;
    logic [3:0]  obs_we;

    assign obs_ready = sel ? bus_b.ready             : bus_a.ready;
    assign obs_err   = sel ? bus_b.error             : bus_a.error;
    assign obs_dout  = sel ? bus_b.data_out          : bus_a.data_out;
    assign obs_addr  = sel ? bus_b.bank_address      : bus_a.bank_address;
    assign obs_wdata = sel ? bus_b.bank_wdata        : bus_a.bank_wdata;
    assign obs_en    = sel ? bus_b.bank_enable       : bus_a.bank_enable;
    assign obs_we    = sel ? bus_b.bank_write_enable : bus_a.bank_write_enable;

    always #5 clk = ~clk;

    // Drive a request at a negedge; the next posedge samples it (edge 1)
    task automatic issue(input logic s, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd);
        sel       = s;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_en    = 1'b1;
    endtask

    // Count edges until ready, collecting strobe activity; edges=-1 if it never comes
    task automatic wait_ready(output int edges, output logic [3:0] en_or,
                              output logic [3:0] we_or, output int en_cyc,
                              output int we_cyc, output logic [3:0] en_rdy);
        edges  = -1;
        en_or  = '0;
        we_or  = '0;
        en_cyc = 0;
        we_cyc = 0;
        en_rdy = '0;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            @(negedge clk);
            en_or = en_or | obs_en;
            we_or = we_or | obs_we;
            if (obs_en != 4'b0000) en_cyc++;
            if (obs_we != 4'b0000) we_cyc++;
            if (obs_ready) begin
                edges  = e;
                en_rdy = obs_en;
                break;
            end
        end
    endtask

    task automatic finish_txn();
        cpu_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #1;
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", obs_err); end
        n_cmp++; if (obs_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", obs_dout); end
        n_cmp++; if (obs_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b want 0000", obs_en); end
        n_cmp++; if (obs_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", obs_addr); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_default();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        rdata_a = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
        rdy_a   = 4'hF;
        issue(1'b0, 1'b0, 16'h0010, 16'h0000);
        sb.push_back('{data: 16'h1234, err: 1'b0, edges: 2});
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL rd0_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL rd0_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL rd0_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (en_or !== 4'b0001) begin n_fail++; $display("FAIL rd0_en: got %b want 0001", en_or); end
        n_cmp++; if (en_c !== 1) begin n_fail++; $display("FAIL rd0_en_cycles: got %0d want 1", en_c); end
        n_cmp++; if (en_rdy !== 4'b0000) begin n_fail++; $display("FAIL rd0_en_done: got %b want 0000", en_rdy); end
        finish_txn();
    endtask

    task automatic test_write_wait();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        rdata_b = {16'hD444, 16'hD333, 16'hD222, 16'hD111};
        rdy_b   = 4'hF;
        issue(1'b1, 1'b1, 16'h2004, 16'hBEEF);
        sb.push_back('{data: 16'h0000, err: 1'b0, edges: 5});
        // Change the request after it has been latched; it must be ignored
        fork
            begin
                @(negedge clk);
                cpu_addr  = 16'h0000;
                cpu_wdata = 16'h0000;
                cpu_we    = 1'b0;
            end
        join_none
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL wr1_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL wr1_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL wr1_dout_kept: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (we_or !== 4'b0010) begin n_fail++; $display("FAIL wr1_we: got %b want 0010", we_or); end
        n_cmp++; if (we_c !== 4) begin n_fail++; $display("FAIL wr1_we_cycles: got %0d want 4", we_c); end
        n_cmp++; if (en_or !== 4'b0010) begin n_fail++; $display("FAIL wr1_en: got %b want 0010", en_or); end
        n_cmp++; if (obs_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr1_wdata: got %h want beef", obs_wdata); end
        n_cmp++; if (obs_addr !== 16'h2004) begin n_fail++; $display("FAIL wr1_addr: got %h want 2004", obs_addr); end
        finish_txn();
    endtask

    task automatic test_unmapped();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        issue(1'b1, 1'b0, 16'h6000, 16'h0000);
        sb.push_back('{data: 16'hFFFF, err: 1'b1, edges: 1});
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL unm_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL unm_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL unm_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (en_or !== 4'b0000) begin n_fail++; $display("FAIL unm_en: got %b want 0000", en_or); end
        finish_txn();
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL unm_error_clear: got %b want 0", obs_err); end
    endtask

    task automatic test_timeout();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        rdy_b = 4'b1011;
        issue(1'b1, 1'b0, 16'h4000, 16'h0000);
        sb.push_back('{data: 16'hFFFF, err: 1'b1, edges: 6});
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL to_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL to_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (en_rdy !== 4'b0000) begin n_fail++; $display("FAIL to_en_done: got %b want 0000", en_rdy); end
        n_cmp++; if (en_c !== 5) begin n_fail++; $display("FAIL to_en_cycles: got %0d want 5", en_c); end
        n_cmp++; if (en_or !== 4'b0100) begin n_fail++; $display("FAIL to_en: got %b want 0100", en_or); end
        finish_txn();
        rdy_b = 4'hF;
    endtask

    task automatic test_delayed_ready();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        rdy_a = 4'b0111;
        issue(1'b0, 1'b0, 16'h6000, 16'h0000);
        sb.push_back('{data: 16'h4444, err: 1'b0, edges: 5});
        // Bank 3 becomes ready after edge 4, so completion happens on edge 5
        fork
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                rdy_a[3] = 1'b1;
            end
        join_none
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL dly_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL dly_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL dly_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (en_or !== 4'b1000) begin n_fail++; $display("FAIL dly_en: got %b want 1000", en_or); end
        finish_txn();
    endtask

    task automatic test_reset_mid();
        rdy_a[3] = 1'b0;
        issue(1'b0, 1'b0, 16'h6000, 16'h0000);
        repeat (2) @(negedge clk);
        n_cmp++; if (obs_en !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_en: got %b want 1000", obs_en); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (obs_en !== 4'b0000) begin n_fail++; $display("FAIL rst_en: got %b want 0000", obs_en); end
        n_cmp++; if (obs_we !== 4'b0000) begin n_fail++; $display("FAIL rst_we: got %b want 0000", obs_we); end
        n_cmp++; if (obs_dout !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", obs_dout); end
        n_cmp++; if (obs_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", obs_addr); end
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", obs_ready); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", obs_err); end
        cpu_en   = 1'b0;
        rdy_a[3] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // The abandoned transaction must not resume
        n_cmp++; if (obs_en !== 4'b0000) begin n_fail++; $display("FAIL rst_abandon_en: got %b want 0000", obs_en); end
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rst_abandon_ready: got %b want 0", obs_ready); end
    endtask

    task automatic test_back_to_back();
        int edges, en_c, we_c;
        logic [3:0] en_or, we_or, en_rdy;
        exp_t e;
        rdata_a[15:0] = 16'h1234;
        issue(1'b0, 1'b0, 16'h0010, 16'h0000);
        sb.push_back('{data: 16'h1234, err: 1'b0, edges: 2});
        // Second request: one edge to return to IDLE, then the normal two
        sb.push_back('{data: 16'h5678, err: 1'b0, edges: 3});
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL b2b0_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL b2b0_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL b2b0_error: got %b want %b", obs_err, e.err); end
        cpu_addr      = 16'h1000;
        rdata_a[15:0] = 16'h5678;
        wait_ready(edges, en_or, we_or, en_c, we_c, en_rdy);
        e = sb.pop_front();
        n_cmp++; if (edges !== e.edges) begin n_fail++; $display("FAIL b2b1_latency: got %0d want %0d", edges, e.edges); end
        n_cmp++; if (obs_dout !== e.data) begin n_fail++; $display("FAIL b2b1_data: got %h want %h", obs_dout, e.data); end
        n_cmp++; if (obs_err !== e.err) begin n_fail++; $display("FAIL b2b1_error: got %b want %b", obs_err, e.err); end
        n_cmp++; if (obs_addr !== 16'h1000) begin n_fail++; $display("FAIL b2b1_addr: got %h want 1000", obs_addr); end
        finish_txn();
        n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drained: got %0d want 0", sb.size()); end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b0;
        sel       = 1'b0;
        cpu_en    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        rdata_a   = '0;
        rdata_b   = '0;
        rdy_a     = 4'hF;
        rdy_b     = 4'hF;
        n_cmp     = 0;
        n_fail    = 0;

        test_reset();
        test_read_default();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_delayed_ready();
        test_reset_mid();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
